// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, fixed latency,
// Stall while outstanding and a one-cycle Ready pulse with the result.
module data_mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [15:0]       Address,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Ready,
    output logic              Err,
    output logic              Stall
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [15:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [ADDR_W-1:0]   idx;
    logic                req;
    logic                oor;
    logic                access;
    logic                mem_we;

    assign req = MemRd | MemWr;
    assign idx = addr_q[ADDR_W-1:0];
    // Shift form stays legal even when ADDR_W covers the whole address.
    assign oor = (addr_q >> ADDR_W) != 16'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = MemWr;
                    addr_d  = Address;
                    wdata_d = Data_in;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                    if (oor) begin
                        err_d = 1'b1;
                        if (!wr_q) dout_d = '0;
                    end else if (!wr_q) begin
                        dout_d = mem[idx];
                    end
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = access & wr_q & ~oor;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a write landing on a reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) mem[idx] <= wdata_q;
    end

    assign Data_out = dout_q;
    assign Err      = err_q;
    assign Ready    = (state_q == RESP);
    assign Stall    = ~RST & (((state_q == IDLE) & req) | (state_q == BUSY));

endmodule
